fc_tcdm_demux_n: RTL and testbench



---
 rtl/fc_tcdm_demux_n.sv | 135 +++++++++++++
 tb/tb_fc_tcdm_demux_n.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_tcdm_demux_n.sv
// N-way address demultiplexer for a TCDM-style core bus.
// Responses return in order because all in-flight transactions go to a single target at a time.
module fc_tcdm_demux_n #(
    parameter int                                  NB_PORTS        = 2,
    parameter int                                  ADDR_WIDTH      = 32,
    parameter int                                  DATA_WIDTH      = 32,
    parameter int                                  MAX_OUTSTANDING = 2,
    parameter logic [NB_PORTS-1:0][ADDR_WIDTH-1:0] START_ADDR      = '0,
    parameter logic [NB_PORTS-1:0][ADDR_WIDTH-1:0] END_ADDR        = '0,
    parameter bit                                  ERR_ON_MISS     = 1'b1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,

    input  logic                                   s_req_i,
    input  logic [ADDR_WIDTH-1:0]                  s_add_i,
    input  logic                                   s_wen_i,
    input  logic [DATA_WIDTH-1:0]                  s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]                s_be_i,
    output logic                                   s_gnt_o,
    output logic                                   s_r_valid_o,
    output logic [DATA_WIDTH-1:0]                  s_r_rdata_o,
    output logic                                   s_r_opc_o,

    output logic [NB_PORTS-1:0]                    m_req_o,
    output logic [NB_PORTS-1:0][ADDR_WIDTH-1:0]    m_add_o,
    output logic [NB_PORTS-1:0]                    m_wen_o,
    output logic [NB_PORTS-1:0][DATA_WIDTH-1:0]    m_wdata_o,
    output logic [NB_PORTS-1:0][DATA_WIDTH/8-1:0]  m_be_o,
    input  logic [NB_PORTS-1:0]                    m_gnt_i,
    input  logic [NB_PORTS-1:0]                    m_r_valid_i,
    input  logic [NB_PORTS-1:0][DATA_WIDTH-1:0]    m_r_rdata_i,
    input  logic [NB_PORTS-1:0]                    m_r_opc_i,

    output logic [3:0]                             outstanding_o,
    output logic                                   spurious_rsp_o
);

    localparam int             PW      = $clog2(NB_PORTS + 1);
    localparam logic [PW-1:0]  ERR_IDX = PW'(NB_PORTS);
    localparam logic [3:0]     MAX_CNT = 4'(MAX_OUTSTANDING);

    logic [3:0]            cnt;
    logic [PW-1:0]         cur_port;
    logic                  err_rsp_q;
    logic                  spurious_q;

    logic [PW-1:0]         target;
    logic                  tgt_err;
    logic                  cur_err;
    logic                  stall;
    logic                  accept;
    logic                  rsp;
    logic                  gnt_port;
    logic                  vld_port;
    logic [DATA_WIDTH-1:0] rdata_port;
    logic                  opc_port;
    logic                  spurious;

    // Descending scan so the lowest matching region wins; empty regions never match.
    always_comb begin
        target = ERR_ON_MISS ? ERR_IDX : '0;
        for (int i = NB_PORTS - 1; i >= 0; i--) begin
            if (START_ADDR[i] < END_ADDR[i] &&
                s_add_i >= START_ADDR[i] && s_add_i < END_ADDR[i]) begin
                target = PW'(i);
            end
        end
    end

    always_comb begin
        gnt_port   = 1'b0;
        vld_port   = 1'b0;
        rdata_port = '0;
        opc_port   = 1'b0;
        spurious   = 1'b0;
        for (int i = 0; i < NB_PORTS; i++) begin
            if (target == PW'(i)) begin
                gnt_port = m_gnt_i[i];
            end
            if (cur_port == PW'(i)) begin
                vld_port   = m_r_valid_i[i];
                rdata_port = m_r_rdata_i[i];
                opc_port   = m_r_opc_i[i];
            end
            if (m_r_valid_i[i] && (cnt == 4'd0 || cur_port != PW'(i))) begin
                spurious = 1'b1;
            end
        end
    end

    assign tgt_err = (target == ERR_IDX);
    assign cur_err = (cur_port == ERR_IDX);
    assign stall   = (cnt == MAX_CNT) || (cnt != 4'd0 && target != cur_port);

    always_comb begin
        for (int i = 0; i < NB_PORTS; i++) begin
            m_req_o[i]   = ~rst_i & s_req_i & ~stall & (target == PW'(i));
            m_add_o[i]   = s_add_i;
            m_wen_o[i]   = s_wen_i;
            m_wdata_o[i] = s_wdata_i;
            m_be_o[i]    = s_be_i;
        end
    end

    assign s_gnt_o = ~rst_i & ~stall & (tgt_err ? s_req_i : gnt_port);
    assign accept  = s_req_i & s_gnt_o;

    assign rsp         = ~rst_i && cnt != 4'd0 && (cur_err ? err_rsp_q : vld_port);
    assign s_r_valid_o = rsp;
    assign s_r_rdata_o = (rsp && !cur_err) ? rdata_port : '0;
    assign s_r_opc_o   = rsp && (cur_err || opc_port);

    assign outstanding_o  = rst_i ? 4'd0 : cnt;
    assign spurious_rsp_o = ~rst_i & spurious_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt        <= 4'd0;
            cur_port   <= '0;
            err_rsp_q  <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            cnt       <= cnt + {3'b000, accept} - {3'b000, rsp};
            err_rsp_q <= accept & tgt_err;
            if (accept) begin
                cur_port <= target;
            end
            if (spurious) begin
                spurious_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fc_tcdm_demux_n.sv
// Bench for fc_tcdm_demux_n: two port memories with controllable response release,
// an in-order response scoreboard, and a second instance with miss-to-port-0 routing.
module tb_fc_tcdm_demux_n;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [NP-1:0][AW-1:0] ST = {32'h1C08_0000, 32'h1C00_0000};
    localparam logic [NP-1:0][AW-1:0] EN = {32'h1C09_0000, 32'h1C08_0000};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                   s_req, s_wen, s_gnt, s_rvalid, s_ropc;
    logic [AW-1:0]          s_add;
    logic [DW-1:0]          s_wdata, s_rdata;
    logic [3:0]             s_be;
    logic [NP-1:0]          m_req, m_wen, m_gnt, m_rvalid, m_ropc;
    logic [NP-1:0][AW-1:0]  m_add;
    logic [NP-1:0][DW-1:0]  m_wdata, m_rdata;
    logic [NP-1:0][3:0]     m_be;
    logic [3:0]             outstanding;
    logic                   spurious;

    logic [NP-1:0]          mv, inj, rel;
    assign m_rvalid = mv | inj;
    assign m_ropc   = '0;

    fc_tcdm_demux_n #(
        .NB_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2),
        .START_ADDR(ST), .END_ADDR(EN), .ERR_ON_MISS(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_req_i(s_req), .s_add_i(s_add), .s_wen_i(s_wen), .s_wdata_i(s_wdata), .s_be_i(s_be),
        .s_gnt_o(s_gnt), .s_r_valid_o(s_rvalid), .s_r_rdata_o(s_rdata), .s_r_opc_o(s_ropc),
        .m_req_o(m_req), .m_add_o(m_add), .m_wen_o(m_wen), .m_wdata_o(m_wdata), .m_be_o(m_be),
        .m_gnt_i(m_gnt), .m_r_valid_i(m_rvalid), .m_r_rdata_i(m_rdata), .m_r_opc_i(m_ropc),
        .outstanding_o(outstanding), .spurious_rsp_o(spurious)
    );

    // Second instance: unmapped addresses fall back to port 0; its ports never grant.
    logic                   s_req2, s_gnt2, s_rvalid2, s_ropc2, spurious2;
    logic [DW-1:0]          s_rdata2;
    logic [NP-1:0]          m_req2, m_wen2;
    logic [NP-1:0][AW-1:0]  m_add2;
    logic [NP-1:0][DW-1:0]  m_wdata2;
    logic [NP-1:0][3:0]     m_be2;
    logic [3:0]             outstanding2;
    logic [NP-1:0]          zero2 = '0;
    logic [NP-1:0][DW-1:0]  zero_data2 = '0;

    fc_tcdm_demux_n #(
        .NB_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2),
        .START_ADDR(ST), .END_ADDR(EN), .ERR_ON_MISS(1'b0)
    ) dut_miss (
        .clk_i(clk), .rst_i(rst),
        .s_req_i(s_req2), .s_add_i(s_add), .s_wen_i(s_wen), .s_wdata_i(s_wdata), .s_be_i(s_be),
        .s_gnt_o(s_gnt2), .s_r_valid_o(s_rvalid2), .s_r_rdata_o(s_rdata2), .s_r_opc_o(s_ropc2),
        .m_req_o(m_req2), .m_add_o(m_add2), .m_wen_o(m_wen2), .m_wdata_o(m_wdata2), .m_be_o(m_be2),
        .m_gnt_i(zero2), .m_r_valid_i(zero2), .m_r_rdata_i(zero_data2), .m_r_opc_i(zero2),
        .outstanding_o(outstanding2), .spurious_rsp_o(spurious2)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_d [$];
    logic          exp_o [$];
    logic [DW-1:0] pq0 [$];
    logic [DW-1:0] pq1 [$];

    function automatic logic [DW-1:0] rdval(input int p, input logic [AW-1:0] a);
        return {4'(p + 1), a[27:0]} ^ 32'h0000_5A5A;
    endfunction

    function automatic int exp_tgt(input logic [AW-1:0] a);
        if (a >= 32'h1C00_0000 && a < 32'h1C08_0000) return 0;
        if (a >= 32'h1C08_0000 && a < 32'h1C09_0000) return 1;
        return 2;
    endfunction

    // Memory model: accepted requests queue a response, released one per cycle when rel is set.
    always @(posedge clk) begin
        if (mv[0] && pq0.size() > 0) void'(pq0.pop_front());
        if (mv[1] && pq1.size() > 0) void'(pq1.pop_front());
        if (m_req[0] && m_gnt[0]) pq0.push_back(rdval(0, s_add));
        if (m_req[1] && m_gnt[1]) pq1.push_back(rdval(1, s_add));
        mv[0]      <= rel[0] && pq0.size() > 0;
        mv[1]      <= rel[1] && pq1.size() > 0;
        m_rdata[0] <= (pq0.size() > 0) ? pq0[0] : '0;
        m_rdata[1] <= (pq1.size() > 0) ? pq1[0] : '0;
    end

    logic [DW-1:0] sb_d;
    logic          sb_o;
    always @(negedge clk) begin
        if (!rst && s_rvalid) begin
            checks++;
            if (exp_d.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: response rdata=%h opc=%b with nothing pending", s_rdata, s_ropc);
            end else begin
                sb_d = exp_d.pop_front();
                sb_o = exp_o.pop_front();
                if (s_rdata !== sb_d || s_ropc !== sb_o) begin
                    errors++;
                    $display("FAIL sb_data: got rdata=%h opc=%b, expected rdata=%h opc=%b",
                             s_rdata, s_ropc, sb_d, sb_o);
                end
            end
        end
    end

    task automatic step(input logic req, input logic [AW-1:0] a);
        int t;
        @(posedge clk);
        #1;
        s_req   = req;
        s_add   = a;
        s_wen   = 1'b1;
        s_wdata = a ^ 32'h0000_FFFF;
        s_be    = 4'hF;
        #1;
        if (s_req && s_gnt) begin
            t = exp_tgt(a);
            if (t == 2) begin
                exp_d.push_back('0);
                exp_o.push_back(1'b1);
            end else begin
                exp_d.push_back(rdval(t, a));
                exp_o.push_back(1'b0);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_req = 1'b1; s_add = 32'h1C00_0010; s_wen = 1'b1; s_wdata = '0; s_be = 4'hF;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (m_req !== 2'b00 || s_gnt !== 1'b0 || s_rvalid !== 1'b0 || s_rdata !== '0 ||
            s_ropc !== 1'b0 || outstanding !== 4'd0 || spurious !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got m_req=%b gnt=%b rv=%b rd=%h opc=%b out=%0d sp=%b, expected all 0",
                     m_req, s_gnt, s_rvalid, s_rdata, s_ropc, outstanding, spurious);
        end
        rst = 1'b0;
        s_req = 1'b0;
        exp_d.delete();
        exp_o.delete();
    endtask

    task automatic test_routing();
        step(1'b1, 32'h1C00_0010);
        checks++;
        if (m_req !== 2'b01 || s_gnt !== 1'b1) begin
            errors++;
            $display("FAIL route_port0: got m_req=%b gnt=%b, expected 01/1", m_req, s_gnt);
        end
        checks++;
        if (m_add[1] !== 32'h1C00_0010 || m_wdata[1] !== (32'h1C00_0010 ^ 32'h0000_FFFF) || m_wen[1] !== 1'b1) begin
            errors++;
            $display("FAIL broadcast: got add1=%h wdata1=%h wen1=%b", m_add[1], m_wdata[1], m_wen[1]);
        end
        step(1'b1, 32'h1C08_0004);
        checks++;
        if (m_req !== 2'b00 || s_gnt !== 1'b0 || s_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL route_switch_stall: got m_req=%b gnt=%b rv=%b, expected 00/0/1", m_req, s_gnt, s_rvalid);
        end
        step(1'b1, 32'h1C08_0004);
        checks++;
        if (m_req !== 2'b10 || s_gnt !== 1'b1) begin
            errors++;
            $display("FAIL route_port1: got m_req=%b gnt=%b, expected 10/1", m_req, s_gnt);
        end
        step(1'b0, 32'h0);
        checks++;
        if (s_rvalid !== 1'b1 || outstanding !== 4'd1) begin
            errors++;
            $display("FAIL route_port1_rsp: got rv=%b out=%0d, expected 1/1", s_rvalid, outstanding);
        end
        step(1'b0, 32'h0);
        checks++;
        if (outstanding !== 4'd0) begin
            errors++;
            $display("FAIL route_drain: got out=%0d, expected 0", outstanding);
        end
    endtask

    task automatic test_throughput();
        int grants = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 32'h1C00_0100 + 32'(4 * k));
            if (s_gnt === 1'b1) grants++;
        end
        checks++;
        if (grants != 6) begin
            errors++;
            $display("FAIL throughput: got %0d grants in 6 cycles, expected 6", grants);
        end
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        checks++;
        if (outstanding !== 4'd0) begin
            errors++;
            $display("FAIL throughput_drain: got out=%0d, expected 0", outstanding);
        end
    endtask

    task automatic test_err();
        step(1'b1, 32'h0000_0000);
        checks++;
        if (s_gnt !== 1'b1 || m_req !== 2'b00) begin
            errors++;
            $display("FAIL err_accept: got gnt=%b m_req=%b, expected 1/00", s_gnt, m_req);
        end
        step(1'b1, 32'h1C09_0000);
        checks++;
        if (s_gnt !== 1'b1 || m_req !== 2'b00 || s_rvalid !== 1'b1 || s_ropc !== 1'b1 || s_rdata !== '0) begin
            errors++;
            $display("FAIL err_rsp1: got gnt=%b m_req=%b rv=%b opc=%b rd=%h, expected 1/00/1/1/0",
                     s_gnt, m_req, s_rvalid, s_ropc, s_rdata);
        end
        step(1'b0, 32'h0);
        checks++;
        if (s_rvalid !== 1'b1 || s_ropc !== 1'b1) begin
            errors++;
            $display("FAIL err_rsp2: got rv=%b opc=%b, expected 1/1", s_rvalid, s_ropc);
        end
        step(1'b0, 32'h0);
        checks++;
        if (s_rvalid !== 1'b0 || s_ropc !== 1'b0 || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL err_idle: got rv=%b opc=%b out=%0d, expected 0/0/0", s_rvalid, s_ropc, outstanding);
        end
    endtask

    task automatic test_outstanding();
        rel[0] = 1'b0;
        step(1'b1, 32'h1C00_0200);
        step(1'b1, 32'h1C00_0204);
        checks++;
        if (s_gnt !== 1'b1 || outstanding !== 4'd1) begin
            errors++;
            $display("FAIL limit_second: got gnt=%b out=%0d, expected 1/1", s_gnt, outstanding);
        end
        step(1'b1, 32'h1C00_0208);
        checks++;
        if (s_gnt !== 1'b0 || m_req !== 2'b00 || outstanding !== 4'd2) begin
            errors++;
            $display("FAIL limit_stall: got gnt=%b m_req=%b out=%0d, expected 0/00/2", s_gnt, m_req, outstanding);
        end
        rel[0] = 1'b1;
        step(1'b1, 32'h1C00_0208);
        checks++;
        if (s_gnt !== 1'b0 || s_rvalid !== 1'b1 || outstanding !== 4'd2) begin
            errors++;
            $display("FAIL limit_rsp_at_max: got gnt=%b rv=%b out=%0d, expected 0/1/2", s_gnt, s_rvalid, outstanding);
        end
        step(1'b1, 32'h1C00_0208);
        checks++;
        if (s_gnt !== 1'b1 || s_rvalid !== 1'b1 || outstanding !== 4'd1) begin
            errors++;
            $display("FAIL limit_accept_rsp: got gnt=%b rv=%b out=%0d, expected 1/1/1", s_gnt, s_rvalid, outstanding);
        end
        step(1'b1, 32'h1C00_020C);
        checks++;
        if (s_gnt !== 1'b1 || s_rvalid !== 1'b1 || outstanding !== 4'd1) begin
            errors++;
            $display("FAIL limit_unchanged: got gnt=%b rv=%b out=%0d, expected 1/1/1", s_gnt, s_rvalid, outstanding);
        end
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        checks++;
        if (outstanding !== 4'd0 || s_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL limit_drain: got out=%0d rv=%b, expected 0/0", outstanding, s_rvalid);
        end
    endtask

    task automatic test_spurious();
        step(1'b0, 32'h0);
        inj = 2'b10;
        #1;
        checks++;
        if (s_rvalid !== 1'b0 || spurious !== 1'b0) begin
            errors++;
            $display("FAIL spur_blocked: got rv=%b sp=%b, expected 0/0", s_rvalid, spurious);
        end
        step(1'b0, 32'h0);
        inj = 2'b00;
        checks++;
        if (spurious !== 1'b1) begin
            errors++;
            $display("FAIL spur_set: got sp=%b, expected 1", spurious);
        end
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        checks++;
        if (spurious !== 1'b1) begin
            errors++;
            $display("FAIL spur_sticky: got sp=%b, expected 1", spurious);
        end
    endtask

    task automatic test_reset_mid();
        rel[0] = 1'b0;
        step(1'b1, 32'h1C00_0300);
        step(1'b1, 32'h1C00_0304);
        step(1'b0, 32'h0);
        checks++;
        if (outstanding !== 4'd2) begin
            errors++;
            $display("FAIL rmid_setup: got out=%0d, expected 2", outstanding);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        s_req = 1'b1;
        s_add = 32'h1C00_0308;
        #1;
        checks++;
        if (m_req !== 2'b00 || s_gnt !== 1'b0 || outstanding !== 4'd0 || spurious !== 1'b0 || s_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_during: got m_req=%b gnt=%b out=%0d sp=%b rv=%b, expected all 0",
                     m_req, s_gnt, outstanding, spurious, s_rvalid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_req = 1'b0;
        exp_d.delete();
        exp_o.delete();
        rel[0] = 1'b1;
        #1;
        checks++;
        if (outstanding !== 4'd0 || spurious !== 1'b0) begin
            errors++;
            $display("FAIL rmid_after: got out=%0d sp=%b, expected 0/0", outstanding, spurious);
        end
        step(1'b0, 32'h0);
        checks++;
        if (m_rvalid[0] !== 1'b1 || s_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_late: got m_rvalid0=%b rv=%b, expected 1/0", m_rvalid[0], s_rvalid);
        end
        step(1'b0, 32'h0);
        checks++;
        if (spurious !== 1'b1) begin
            errors++;
            $display("FAIL rmid_spur: got sp=%b, expected 1", spurious);
        end
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
    endtask

    task automatic test_miss_port0();
        logic [AW-1:0] addrs [4];
        logic [NP-1:0] exp_req [4];
        addrs[0] = 32'h0000_0000; exp_req[0] = 2'b01;
        addrs[1] = 32'h1C07_FFFC; exp_req[1] = 2'b01;
        addrs[2] = 32'h1C08_0000; exp_req[2] = 2'b10;
        addrs[3] = 32'h1C09_0000; exp_req[3] = 2'b01;
        @(posedge clk);
        #1;
        s_req2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_add = addrs[k];
            #1;
            checks++;
            if (m_req2 !== exp_req[k] || s_gnt2 !== 1'b0) begin
                errors++;
                $display("FAIL miss_route[%0d]: addr=%h got m_req=%b gnt=%b, expected %b/0",
                         k, addrs[k], m_req2, s_gnt2, exp_req[k]);
            end
        end
        s_req2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        s_req2 = 1'b0;
        m_gnt  = 2'b11;
        rel    = 2'b11;
        inj    = 2'b00;
        test_reset();
        test_routing();
        test_throughput();
        test_err();
        test_outstanding();
        test_spurious();
        test_reset_mid();
        test_miss_port0();
        step(1'b0, 32'h0);
        checks++;
        if (exp_d.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d responses still pending, expected 0", exp_d.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
